// File: rtl/dbg_pkg.sv
// dbg_pkg: seven-segment constants, hex-to-segment decoder and BCD digit count shared by the debug display
package dbg_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam int BCD_DIGITS = 5;
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble, one load cycle then 16 shift/add-3 cycles; only built with DBG_SSD_BCD_EN
`ifdef DBG_SSD_BCD_EN
module bin2bcd_seq
  import dbg_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             bin,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    busy
);
  logic [15:0] sh;
  logic [4*BCD_DIGITS-1:0] acc, adj;
  logic [4:0] cnt;
  // add 3 to every BCD digit of 5 or more ahead of the shift
  always_comb begin
    adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  // cnt 0 loads the operand, cnt 1..16 shift; the result is published on the edge busy falls
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt <= '0;
      sh <= '0;
      acc <= '0;
      bcd <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 5'd1;
      if (cnt == 5'd0) begin
        sh <= bin;
        acc <= '0;
      end else begin
        {acc, sh} <= {adj[4*BCD_DIGITS-2:0], sh, 1'b0};
        if (cnt == 5'd16) begin
          busy <= 1'b0;
          bcd <= {adj[4*BCD_DIGITS-2:0], sh[15]};
        end
      end
    end
  end
endmodule
`endif

// File: rtl/dbg_ssd_scanner.sv
// dbg_ssd_scanner: per-frame channel snapshot scanned onto a multiplexed 7-seg display; decimal mode needs DBG_SSD_BCD_EN
module dbg_ssd_scanner
  import dbg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 32,
  parameter int REFRESH_DIV = 100000,
  parameter int SEL_W       = $clog2(NUM_CH),
  parameter int PAGE_W      = (DATA_W / (4 * NUM_DIGITS)) > 1 ? $clog2(DATA_W / (4 * NUM_DIGITS)) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         sel,
  input  logic [PAGE_W-1:0]        page,
  input  logic                     dec_mode,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_DIGITS-1:0]    annode,
  output logic [6:0]               cathod,
  output logic                     busy
);
  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int DIG_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int NIBS = DATA_W / 4;
  logic [DIV_W-1:0] div;
  logic [DIG_W-1:0] dig;
  logic [DATA_W-1:0] snap, snap_nx, chan;
  logic [PAGE_W-1:0] page_q, page_nx;
  logic dec_q, dec_nx, tick, frame, ovf;
  logic [3:0] nib, bd;
  logic [6:0] seg;
  logic [4*BCD_DIGITS-1:0] bcd;
  // dig names the digit presented at the next tick, so a tick with dig 0 opens a frame
  assign tick = div == DIV_W'(REFRESH_DIV - 1);
  assign frame = tick && dig == '0;
  assign snap_nx = frame ? chan : snap;
  assign page_nx = frame ? page : page_q;
  assign ovf = |(bcd >> (4 * NUM_DIGITS));
`ifdef DBG_SSD_BCD_EN
  assign dec_nx = frame ? dec_mode : dec_q;
  bin2bcd_seq u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(frame),
    .bin  (snap[15:0]),
    .bcd  (bcd),
    .busy (busy)
  );
`else
  logic unused_dec;
  assign unused_dec = dec_mode ^ dec_q;
  assign dec_nx = 1'b0;
  assign bcd = '0;
  assign busy = 1'b0;
`endif
  // channel mux; selects past NUM_CH read as zero
  always_comb begin
    chan = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (sel == SEL_W'(k)) chan = ch_data[k*DATA_W +: DATA_W];
  end
  // hex nibble and BCD digit for the digit about to be shown, using the values latched this tick
  always_comb begin
    nib = '0;
    bd = '0;
    for (int i = 0; i < NIBS; i++)
      if (int'(page_nx) * NUM_DIGITS + int'(dig) == i) nib = snap_nx[4*i +: 4];
    for (int i = 0; i < BCD_DIGITS; i++)
      if (int'(dig) == i) bd = bcd[4*i +: 4];
    seg = !dec_nx ? hex2seg(nib) : ovf && dig == DIG_W'(NUM_DIGITS - 1) ? SEG_DASH : hex2seg(bd);
  end
  // refresh divider, scan counter, frame snapshot and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      dig <= '0;
      snap <= '0;
      page_q <= '0;
      dec_q <= 1'b0;
      annode <= '1;
      cathod <= SEG_BLANK;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        dig <= dig == DIG_W'(NUM_DIGITS - 1) ? '0 : dig + 1'b1;
        snap <= snap_nx;
        page_q <= page_nx;
        dec_q <= dec_nx;
        annode <= ~(NUM_DIGITS'(1) << dig);
        cathod <= seg;
      end
    end
  end
endmodule

// File: tb/tb_dbg_ssd_scanner.sv
// tb_dbg_ssd_scanner: randomized scoreboard bench checking dbg_ssd_scanner against a frame-level display model
module tb_dbg_ssd_scanner;
  localparam int ND = 4, DW = 32, NC = 5, RD = 32, SW = 3, PW = 1;
`ifdef DBG_SSD_BCD_EN
  localparam bit BCD = 1'b1;
`else
  localparam bit BCD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, dec_mode = 1'b0;
  logic [SW-1:0] sel = '0;
  logic [PW-1:0] page = '0;
  logic [NC*DW-1:0] ch_data = '0;
  logic [ND-1:0] annode;
  logic [6:0] cathod;
  logic busy;
  int total = 0, bad = 0;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [10:0] q [$];
  int phase = 0, nd = 0, bl = 0, pg = 0, conv = 0, pend = 0;
  logic [31:0] sn = '0;
  bit dm = 1'b0, rst_e = 1'b0;

  dbg_ssd_scanner #(.NUM_DIGITS(ND), .DATA_W(DW), .NUM_CH(NC), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .sel(sel), .page(page), .dec_mode(dec_mode),
    .ch_data(ch_data), .annode(annode), .cathod(cathod), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [6:0] exp_seg(input int d);
    int idx;
    if (dm) return (d == ND - 1 && conv >= 10 ** ND) ? 7'h3F : seg_tab[(conv / (10 ** d)) % 10];
    idx = pg * ND + d;
    return idx < DW / 4 ? seg_tab[int'((sn >> (4 * idx)) & 32'hF)] : seg_tab[0];
  endfunction

  // reference model: one digit slot every RD cycles, snapshot when digit 0 comes up, conversions last 17 cycles
  initial forever begin
    logic [3:0] an;
    @(posedge clk);
    rst_e = rst;
    if (rst) begin
      phase = 0; nd = 0; bl = 0; conv = 0; q.delete();
    end else begin
      if (bl > 0) begin
        bl--;
        if (bl == 0) conv = pend;
      end
      if (phase == RD - 1) begin
        phase = 0;
        if (nd == 0) begin
          sn = int'(sel) < NC ? ch_data[int'(sel)*DW +: DW] : 32'h0;
          pg = int'(page);
          dm = BCD && dec_mode;
          pend = int'(sn[15:0]);
          bl = BCD ? 17 : 0;
        end
        an = ~(4'b0001 << nd);
        q.push_back({an, exp_seg(nd)});
        nd = (nd + 1) % ND;
      end else phase++;
    end
  end

  // monitor: reset state, busy every cycle, and each new digit slot against the scoreboard
  initial begin
    logic [ND-1:0] last;
    logic [10:0] e;
    int hold, rel;
    bit first;
    last = '1; hold = 0; rel = 0; first = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_e) begin
        chk("rst_annode", int'(annode), 'hF);
        chk("rst_cathod", int'(cathod), 'h7F);
        chk("rst_busy", int'(busy), 0);
        last = '1; hold = 0; rel = 0; first = 1'b1;
      end else begin
        rel++;
        chk("busy", int'(busy), int'(bl > 0));
        if (annode != last) begin
          if (first) chk("first_digit_latency", rel, RD);
          else chk("digit_hold", hold, RD);
          if (q.size() == 0) chk("unexpected_digit", int'({annode, cathod}), -1);
          else begin
            e = q.pop_front();
            chk("digit", int'({annode, cathod}), int'(e));
          end
          last = annode; hold = 1; first = 1'b0;
        end else hold++;
      end
    end
  end

  // stimulus: directed frames from the test plan, then random changes at random times
  initial begin
    int k;
    for (int i = 0; i < NC; i++) ch_data[i*DW +: DW] = $urandom;
    ch_data[1*DW +: DW] = 32'h1234ABCD;
    ch_data[2*DW +: 16] = 16'd9876;
    ch_data[3*DW +: 16] = 16'd65535;
    sel = 3'd1;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(8 * RD);
    page = 1'b1;
    cycles(8 * RD);
    sel = 3'd5;
    cycles(8 * RD);
    page = 1'b0;
    sel = 3'd2;
    dec_mode = 1'b1;
    cycles(12 * RD);
    sel = 3'd3;
    cycles(8 * RD);
    dec_mode = 1'b0;
    sel = 3'd1;
    for (int i = 0; i < 300 && annode != 4'b1011; i++) @(negedge clk);
    sel = 3'd0;
    cycles(8 * RD);
    for (int n = 0; n < 40; n++) begin
      cycles($urandom_range(1, 200));
      case ($urandom_range(0, 4))
        0: sel = SW'($urandom_range(0, 7));
        1: page = PW'($urandom_range(0, 1));
        2: dec_mode = ~dec_mode;
        3: begin k = $urandom_range(0, NC - 1); ch_data[k*DW +: DW] = $urandom; end
        default: begin k = $urandom_range(0, NC - 1); ch_data[k*DW +: 16] = 16'($urandom_range(0, 12000)); end
      endcase
    end
    dec_mode = 1'b1;
    sel = 3'd2;
`ifdef DBG_SSD_BCD_EN
    for (int i = 0; i < 600 && !busy; i++) @(negedge clk);
    chk("busy_seen", int'(busy), 1);
    cycles(5);
`else
    cycles(2 * RD + 7);
`endif
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    cycles(10 * RD);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
